io_arbiter: RTL and testbench

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_arbiter.sv | 152 +++++++++++++++
 tb/tb_io_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// io_arbiter: two-requester (CPU, debug loader) arbiter onto a shared IO bus.
// One transaction in flight; IDLE -> ACCESS -> DONE. Ties alternate round-robin,
// with the CPU winning the first tie after reset.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_cpu_req/we/addr/wdata       CPU request (we: 1=write, 0=read)
//   o_cpu_rdata, o_cpu_ack        CPU read data, one-cycle completion pulse
//   i_dbg_req/we/addr/wdata       debug-loader request
//   o_dbg_rdata, o_dbg_ack        debug read data, one-cycle completion pulse
//   o_io_address/o_io_write_value shared bus address and write data
//   o_io_read_en/o_io_write_en    bus strobes, only during ACCESS
//   i_io_read_value, i_io_ready   peripheral read data and completion
//   o_bus_err                     one-cycle pulse with ack on timeout
//
// Optional feature: define IO_ARBITER_TIMEOUT_EN to terminate an ACCESS after
// TIMEOUT_CYCLES cycles without i_io_ready (reads then return 16'hFFFF).
module io_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_ack,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [15:0] i_dbg_addr,
  input  logic [15:0] i_dbg_wdata,
  output logic [15:0] o_dbg_rdata,
  output logic        o_dbg_ack,
  output logic [15:0] o_io_address,
  output logic [15:0] o_io_write_value,
  output logic        o_io_read_en,
  output logic        o_io_write_en,
  input  logic [15:0] i_io_read_value,
  input  logic        i_io_ready,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_last_dbg;   // 1: debug port was granted last
  logic        r_grant_dbg;  // 1: current transaction belongs to the debug port
  logic        r_we;
  logic [15:0] r_io_address;
  logic [15:0] r_io_write_value;
  logic [15:0] r_cpu_rdata;
  logic [15:0] r_dbg_rdata;
  logic        w_pick_dbg;
  logic        w_timeout;

`ifdef IO_ARBITER_TIMEOUT_EN
  logic [7:0]  r_cnt;
  logic        r_timed_out;
`else
  logic        w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    w_state_next = r_state;
    // Debug wins if alone, or on a tie when the CPU was granted last.
    w_pick_dbg   = i_dbg_req & (~i_cpu_req | ~r_last_dbg);
    w_timeout    = 1'b0;
`ifdef IO_ARBITER_TIMEOUT_EN
    w_timeout    = (r_cnt == 8'(TIMEOUT_CYCLES - 1)) & ~i_io_ready;
`endif
    case (r_state)
      StIdle:   if (i_cpu_req | i_dbg_req) w_state_next = StAccess;
      StAccess: if (i_io_ready | w_timeout) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= StIdle;
      r_last_dbg       <= 1'b1;
      r_grant_dbg      <= 1'b0;
      r_we             <= 1'b0;
      r_io_address     <= 16'h0000;
      r_io_write_value <= 16'h0000;
      r_cpu_rdata      <= 16'h0000;
      r_dbg_rdata      <= 16'h0000;
`ifdef IO_ARBITER_TIMEOUT_EN
      r_cnt            <= 8'h00;
      r_timed_out      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_cpu_req | i_dbg_req) begin
            r_grant_dbg      <= w_pick_dbg;
            r_we             <= w_pick_dbg ? i_dbg_we    : i_cpu_we;
            r_io_address     <= w_pick_dbg ? i_dbg_addr  : i_cpu_addr;
            r_io_write_value <= w_pick_dbg ? i_dbg_wdata : i_cpu_wdata;
`ifdef IO_ARBITER_TIMEOUT_EN
            r_cnt            <= 8'h00;
            r_timed_out      <= 1'b0;
`endif
          end
        end
        StAccess: begin
          if (i_io_ready) begin
            if (!r_we) begin
              if (r_grant_dbg) r_dbg_rdata <= i_io_read_value;
              else             r_cpu_rdata <= i_io_read_value;
            end
          end else if (w_timeout) begin
`ifdef IO_ARBITER_TIMEOUT_EN
            r_timed_out <= 1'b1;
`endif
            if (!r_we) begin
              if (r_grant_dbg) r_dbg_rdata <= 16'hFFFF;
              else             r_cpu_rdata <= 16'hFFFF;
            end
          end else begin
`ifdef IO_ARBITER_TIMEOUT_EN
            r_cnt <= r_cnt + 8'h01;
`endif
          end
        end
        StDone: r_last_dbg <= r_grant_dbg;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so reset drops them asynchronously.
  assign o_io_read_en     = (r_state == StAccess) & ~r_we;
  assign o_io_write_en    = (r_state == StAccess) &  r_we;
  assign o_cpu_ack        = (r_state == StDone) & ~r_grant_dbg;
  assign o_dbg_ack        = (r_state == StDone) &  r_grant_dbg;
  assign o_io_address     = r_io_address;
  assign o_io_write_value = r_io_write_value;
  assign o_cpu_rdata      = r_cpu_rdata;
  assign o_dbg_rdata      = r_dbg_rdata;
`ifdef IO_ARBITER_TIMEOUT_EN
  assign o_bus_err        = (r_state == StDone) & r_timed_out;
`else
  assign o_bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_io_arbiter.sv
module tb_io_arbiter;

  typedef struct packed {
    logic        is_dbg;
    logic [15:0] rdata;
    logic        err;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0, dbg_wdata = '0;
  logic [15:0] dbg_rdata;
  logic        dbg_ack;
  logic [15:0] io_address, io_write_value;
  logic        io_read_en, io_write_en;
  logic [15:0] io_read_value = '0;
  logic        io_ready = 1'b0;
  logic        bus_err;

  int total = 0;
  int bad = 0;
  sb_t sb[$];
  logic [15:0] exp_cpu = '0;
  logic [15:0] exp_dbg = '0;

  io_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cpu_req        (cpu_req),
    .i_cpu_we         (cpu_we),
    .i_cpu_addr       (cpu_addr),
    .i_cpu_wdata      (cpu_wdata),
    .o_cpu_rdata      (cpu_rdata),
    .o_cpu_ack        (cpu_ack),
    .i_dbg_req        (dbg_req),
    .i_dbg_we         (dbg_we),
    .i_dbg_addr       (dbg_addr),
    .i_dbg_wdata      (dbg_wdata),
    .o_dbg_rdata      (dbg_rdata),
    .o_dbg_ack        (dbg_ack),
    .o_io_address     (io_address),
    .o_io_write_value (io_write_value),
    .o_io_read_en     (io_read_en),
    .o_io_write_en    (io_write_en),
    .i_io_read_value  (io_read_value),
    .i_io_ready       (io_ready),
    .o_bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every ack pops one expected completion.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (io_read_en && io_write_en) begin
        total++; bad++;
        $display("FAIL strobe_excl: read_en=%b write_en=%b, required not both", io_read_en,
                 io_write_en);
      end
      if (cpu_ack || dbg_ack) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: cpu_ack=%b dbg_ack=%b, required none", cpu_ack, dbg_ack);
        end else begin
          e = sb.pop_front();
          total++;
          if ({dbg_ack, cpu_ack} !== (e.is_dbg ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL ack_port: got {dbg,cpu}=%b%b, required dbg=%b", dbg_ack, cpu_ack,
                     e.is_dbg);
          end
          total++;
          if ((e.is_dbg ? dbg_rdata : cpu_rdata) !== e.rdata) begin
            bad++;
            $display("FAIL ack_rdata: got %h, required %h (dbg=%b)",
                     e.is_dbg ? dbg_rdata : cpu_rdata, e.rdata, e.is_dbg);
          end
          total++;
          if (bus_err !== e.err) begin
            bad++;
            $display("FAIL ack_bus_err: got %b, required %b", bus_err, e.err);
          end
        end
      end else if (bus_err !== 1'b0) begin
        total++; bad++;
        $display("FAIL stray_bus_err: got %b, required 0", bus_err);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0; io_ready = 1'b0;
    exp_cpu = 16'h0000; exp_dbg = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({io_read_en, io_write_en, cpu_ack, dbg_ack, bus_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {io_read_en, io_write_en, cpu_ack, dbg_ack, bus_err});
    end
    total++;
    if ({io_address, io_write_value} !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0", io_address, io_write_value);
    end
    total++;
    if ({cpu_rdata, dbg_rdata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got cpu=%h dbg=%h, required 0", cpu_rdata, dbg_rdata);
    end
    apply_reset();
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8001;
    exp_cpu = 16'h1234;
    sb.push_back('{is_dbg: 1'b0, rdata: 16'h1234, err: 1'b0});
    @(posedge clk); #1;
    io_ready = 1'b1; io_read_value = 16'h1234;
    @(negedge clk);
    total++;
    if ({io_read_en, io_write_en, cpu_ack} !== 3'b100 || io_address !== 16'h8001) begin
      bad++;
      $display("FAIL cpu_read_access: got rd=%b wr=%b ack=%b addr=%h, required 1 0 0 8001",
               io_read_en, io_write_en, cpu_ack, io_address);
    end
    @(posedge clk); #1;
    io_ready = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b1 || io_read_en !== 1'b0) begin
      bad++;
      $display("FAIL cpu_read_latency: got ack=%b rd=%b, required ack=1 rd=0", cpu_ack,
               io_read_en);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b0 || io_read_en !== 1'b0) begin
      bad++;
      $display("FAIL cpu_read_pulse: got ack=%b rd=%b, required 0 0", cpu_ack, io_read_en);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_addr [3];
    int n_ack = 0;
    int n_grant = 0;
    exp_addr[0] = 16'h0010; exp_addr[1] = 16'h0020; exp_addr[2] = 16'h0010;
    apply_reset();
    sb.push_back('{is_dbg: 1'b0, rdata: 16'h5A4A, err: 1'b0});
    sb.push_back('{is_dbg: 1'b1, rdata: 16'h5A7A, err: 1'b0});
    sb.push_back('{is_dbg: 1'b0, rdata: 16'h5A4A, err: 1'b0});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0020;
    for (int i = 0; i < 40 && n_ack < 3; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) n_ack++;
      if (io_read_en) begin
        if (n_grant < 3) begin
          total++;
          if (io_address !== exp_addr[n_grant]) begin
            bad++;
            $display("FAIL rr_order%0d: got addr %h, required %h", n_grant, io_address,
                     exp_addr[n_grant]);
          end
        end
        n_grant++;
      end
      io_ready = io_read_en | io_write_en;
      io_read_value = io_address ^ 16'h5A5A;
    end
    cpu_req = 1'b0; dbg_req = 1'b0; io_ready = 1'b0;
    exp_cpu = 16'h5A4A; exp_dbg = 16'h5A7A;
    total++;
    if (n_ack != 3 || n_grant != 3) begin
      bad++;
      $display("FAIL rr_count: got acks=%0d grants=%0d, required 3 3", n_ack, n_grant);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_wait();
    int n_hi = 0;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h8002; dbg_wdata = 16'hA5A5;
    sb.push_back('{is_dbg: 1'b1, rdata: exp_dbg, err: 1'b0});
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (io_write_en === 1'b1 && io_read_en === 1'b0 && io_address === 16'h8002 &&
          io_write_value === 16'hA5A5 && dbg_ack === 1'b0) n_hi++;
      if (k == 4) io_ready = 1'b1;
    end
    total++;
    if (n_hi != 5) begin
      bad++;
      $display("FAIL write_hold: got %0d stable strobe cycles, required 5", n_hi);
    end
    @(negedge clk);
    total++;
    if (dbg_ack !== 1'b1 || io_write_en !== 1'b0 || dbg_rdata !== exp_dbg) begin
      bad++;
      $display("FAIL write_done: got ack=%b wr=%b rdata=%h, required 1 0 %h", dbg_ack,
               io_write_en, dbg_rdata, exp_dbg);
    end
    dbg_req = 1'b0; io_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n_hi = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8003;
    io_read_value = 16'h1234; io_ready = 1'b0;
`ifdef IO_ARBITER_TIMEOUT_EN
    sb.push_back('{is_dbg: 1'b0, rdata: 16'hFFFF, err: 1'b1});
    exp_cpu = 16'hFFFF;
    @(posedge clk);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (io_read_en) n_hi++;
      if (cpu_ack) got = 1'b1;
    end
    total++;
    if (n_hi != 15 || !got) begin
      bad++;
      $display("FAIL timeout: got %0d strobe cycles ack=%b, required 15 and ack", n_hi, got);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if ({cpu_ack, bus_err, io_read_en} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_pulse: got ack=%b err=%b rd=%b, required 000", cpu_ack, bus_err,
               io_read_en);
    end
`else
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io_read_en === 1'b1 && cpu_ack === 1'b0) n_hi++;
    end
    total++;
    if (n_hi != 20) begin
      bad++;
      $display("FAIL no_timeout: got %0d strobe cycles, required 20", n_hi);
    end
    sb.push_back('{is_dbg: 1'b0, rdata: 16'h0BAD, err: 1'b0});
    exp_cpu = 16'h0BAD;
    io_ready = 1'b1; io_read_value = 16'h0BAD;
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b1 || bus_err !== 1'b0) begin
      bad++;
      $display("FAIL late_ready: got ack=%b err=%b, required 1 0", cpu_ack, bus_err);
    end
    cpu_req = 1'b0; io_ready = 1'b0;
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8004; cpu_wdata = 16'h1111;
    io_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (io_write_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got wr=%b, required 1", io_write_en);
    end
    #1 rst_n = 1'b0;
    exp_cpu = 16'h0000; exp_dbg = 16'h0000;
    #1;
    total++;
    if ({io_write_en, io_read_en, cpu_ack} !== 3'b000 || io_address !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset: got wr=%b rd=%b ack=%b addr=%h, required 0 0 0 0000",
               io_write_en, io_read_en, cpu_ack, io_address);
    end
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL mid_noack: got ack=%b, required 0", cpu_ack);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{is_dbg: 1'b0, rdata: 16'h0000, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    total++;
    if (io_write_en !== 1'b1 || io_address !== 16'h8004 || io_write_value !== 16'h1111) begin
      bad++;
      $display("FAIL mid_regrant: got wr=%b addr=%h data=%h, required 1 8004 1111", io_write_en,
               io_address, io_write_value);
    end
    io_ready = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b1) begin
      bad++;
      $display("FAIL mid_complete: got ack=%b, required 1", cpu_ack);
    end
    cpu_req = 1'b0; io_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_write_wait();
    test_timeout();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
